// File: rtl/mem_pkg.sv
// Shared memory-protocol definitions: bus widths and requester FSM states.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RMW_ISSUE,
    ST_RMW_WAIT,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RESP
  } mem_req_state_t;

  // Word-aligned byte address: low two bits forced to zero.
  function automatic logic [MEM_ADDR_W-1:0] word_align(input logic [MEM_ADDR_W-1:0] a);
    return a & ~(MEM_ADDR_W'(3));
  endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational per-byte-lane merge: lanes with byte enable set take the new
// data, the others keep the old data.
module mem_byte_merge
  import mem_pkg::*;
#(
  parameter int NUM_LANES = MEM_BE_W
) (
  input  logic [NUM_LANES-1:0][7:0] i_old,
  input  logic [NUM_LANES-1:0][7:0] i_new,
  input  logic [NUM_LANES-1:0]      i_be,
  output logic [NUM_LANES-1:0][7:0] o_merged
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign o_merged[i] = i_be[i] ? i_new[i] : i_old[i];
  end

endmodule

// File: rtl/mem_requester.sv
// Initiator for the delayed word-memory protocol. One core load/store at a
// time; each memory request is a single-cycle pulse, completion is mem_ack.
// Partial stores run as read-modify-write.
// Optional feature macro: MEM_REQUESTER_TIMEOUT_EN (WAIT-state timeout with
// core_err response). Without it the WAIT states wait forever and core_err=0.
module mem_requester
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_rd_req,
  input  logic                  core_wr_req,
  input  logic [MEM_ADDR_W-1:0] core_addr,
  input  logic [MEM_DATA_W-1:0] core_wr_data,
  input  logic [MEM_BE_W-1:0]   core_byte_en,
  output logic                  core_ready,
  output logic                  core_rsp_valid,
  output logic [MEM_DATA_W-1:0] core_rd_data,
  output logic                  core_err,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wr_data,
  input  logic                  mem_busy,
  input  logic                  mem_ack,
  input  logic [MEM_DATA_W-1:0] mem_rd_data
);

  mem_req_state_t        r_state;
  logic                  r_mem_rd_req;
  logic                  r_mem_wr_req;
  logic                  r_rsp_valid;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [MEM_DATA_W-1:0] r_mem_wr_data;
  logic [MEM_DATA_W-1:0] r_core_wdata;
  logic [MEM_BE_W-1:0]   r_be;
  logic [MEM_DATA_W-1:0] r_rd_data;
  logic [MEM_DATA_W-1:0] w_merged;
  logic                  w_ready;
  logic                  w_tmo;

  assign w_ready        = !rst && (r_state == ST_IDLE) && !mem_busy;
  assign core_ready     = w_ready;
  assign core_rsp_valid = r_rsp_valid;
  assign core_rd_data   = r_rd_data;
  assign mem_rd_req     = r_mem_rd_req;
  assign mem_wr_req     = r_mem_wr_req;
  assign mem_addr       = r_mem_addr;
  assign mem_wr_data    = r_mem_wr_data;

  // RMW: memory word is the old data, the latched store word is the new data.
  mem_byte_merge #(.NUM_LANES(MEM_BE_W)) u_merge (
    .i_old    (mem_rd_data),
    .i_new    (r_core_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_pend;
  logic          r_err;
  logic          w_in_wait;

  assign w_in_wait = (r_state == ST_RD_WAIT) || (r_state == ST_RMW_WAIT) ||
                     (r_state == ST_WR_WAIT);
  // Timeout fires on the last allowed WAIT cycle unless ack arrives in it.
  assign w_tmo     = w_in_wait && !mem_ack && (r_tmo_cnt == TMO_LAST);
  assign core_err  = r_err;

  // WAIT-cycle counter, restarted at every issue; error flag rides to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt  <= '0;
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE:                                r_err_pend <= 1'b0;
        ST_RD_ISSUE, ST_RMW_ISSUE, ST_WR_ISSUE: r_tmo_cnt  <= '0;
        ST_RD_WAIT, ST_RMW_WAIT, ST_WR_WAIT: begin
          if (!mem_ack) r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (w_tmo)    r_err_pend <= 1'b1;
        end
        ST_RESP:                                r_err <= r_err_pend;
        default: ;
      endcase
    end
  end
`else
  assign w_tmo    = 1'b0;
  assign core_err = 1'b0;
`endif

  // Main transaction FSM; request pulses and the response pulse are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mem_rd_req  <= 1'b0;
      r_mem_wr_req  <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
      r_core_wdata  <= '0;
      r_be          <= '0;
      r_rd_data     <= '0;
    end else begin
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_rsp_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ready && core_wr_req) begin
            // Store wins; a simultaneous load is dropped.
            r_mem_addr    <= word_align(core_addr);
            r_mem_wr_data <= core_wr_data;
            r_core_wdata  <= core_wr_data;
            r_be          <= core_byte_en;
            if (core_byte_en == '1) begin
              r_mem_wr_req <= 1'b1;
              r_state      <= ST_WR_ISSUE;
            end else if (core_byte_en == '0) begin
              r_state      <= ST_RESP;
            end else begin
              r_mem_rd_req <= 1'b1;
              r_state      <= ST_RMW_ISSUE;
            end
          end else if (w_ready && core_rd_req) begin
            r_mem_addr   <= word_align(core_addr);
            r_mem_rd_req <= 1'b1;
            r_state      <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE:  r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (mem_ack) begin
            r_rd_data <= mem_rd_data;
            r_state   <= ST_RESP;
          end else if (w_tmo) begin
            r_state   <= ST_RESP;
          end
        end
        ST_RMW_ISSUE: r_state <= ST_RMW_WAIT;
        ST_RMW_WAIT: begin
          if (mem_ack) begin
            r_mem_wr_data <= w_merged;
            r_mem_wr_req  <= 1'b1;
            r_state       <= ST_WR_ISSUE;
          end else if (w_tmo) begin
            r_state       <= ST_RESP;
          end
        end
        ST_WR_ISSUE:  r_state <= ST_WR_WAIT;
        ST_WR_WAIT: begin
          if (mem_ack || w_tmo) r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester against a 4-wait-state delayed word memory.
// Directed table, reset-abort sequence, randomized traffic vs a shadow memory,
// and (when MEM_REQUESTER_TIMEOUT_EN is defined) a suppressed-ack timeout.
module tb_mem_requester;

`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rd_req, core_wr_req;
  logic [31:0] core_addr, core_wr_data;
  logic [3:0]  core_byte_en;
  logic        core_ready, core_rsp_valid, core_err;
  logic [31:0] core_rd_data;
  logic        mem_rd_req, mem_wr_req;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_busy, mem_ack;
  logic [31:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_requester #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
    .core_addr(core_addr), .core_wr_data(core_wr_data), .core_byte_en(core_byte_en),
    .core_ready(core_ready), .core_rsp_valid(core_rsp_valid),
    .core_rd_data(core_rd_data), .core_err(core_err),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  // ---------------- delayed memory model (4 wait states) ----------------
  logic        m_busy, m_ack, m_wr, m_sup;
  logic [1:0]  m_cnt;
  logic [7:0]  m_a;
  logic [31:0] m_wd, m_rq;
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_a;
  logic [31:0] pl_d;

  assign mem_busy    = m_busy;
  assign mem_ack     = m_ack;
  assign mem_rd_data = m_rq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ack  <= 1'b0;
      m_cnt  <= 2'd0;
    end else begin
      m_ack <= 1'b0;
      if (pl_en) mem[pl_a] <= pl_d;
      if (m_busy) begin
        if (m_cnt == 2'd3) begin
          m_busy <= 1'b0;
          if (!m_sup) m_ack <= 1'b1;
          if (m_wr) mem[m_a] <= m_wd;
          else      m_rq <= mem[m_a];
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end else if (mem_rd_req || mem_wr_req) begin
        m_busy <= 1'b1;
        m_cnt  <= 2'd0;
        m_wr   <= mem_wr_req;
        m_a    <= mem_addr[9:2];
        m_wd   <= mem_wr_data;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One core transaction; latency = posedges after the accept edge until
  // core_rsp_valid is seen.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] be,
                     input int exp_lat, input int exp_nrd, input int exp_nwr,
                     input logic [31:0] exp_rdata, input logic [31:0] exp_wdata,
                     input logic exp_err, input string tag);
    int g, n, nrd, nwr;
    bit seen;
    g = 0;
    while (!core_ready && g < 50) begin @(negedge clk); g++; end
    chk({tag, "/ready_in"}, {31'd0, core_ready}, 32'd1);
    core_wr_req = wr; core_rd_req = rd; core_addr = addr;
    core_wr_data = data; core_byte_en = be;
    @(posedge clk);
    n = -1; nrd = 0; nwr = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      core_wr_req = 1'b0; core_rd_req = 1'b0;
      if (mem_rd_req) begin
        nrd++;
        chk({tag, "/rd_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
      end
      if (mem_wr_req) begin
        nwr++;
        chk({tag, "/wr_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "/wr_data"}, mem_wr_data, exp_wdata);
      end
      if (core_rsp_valid) seen = 1'b1;
    end
    chk({tag, "/latency"}, n, exp_lat);
    chk({tag, "/n_rd"}, nrd, exp_nrd);
    chk({tag, "/n_wr"}, nwr, exp_nwr);
    chk({tag, "/rd_data"}, core_rd_data, exp_rdata);
    chk({tag, "/err"}, {31'd0, core_err}, {31'd0, exp_err});
    chk({tag, "/ready_rsp"}, {31'd0, core_ready}, 32'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          pl;
    logic [7:0]  pw;
    logic [31:0] pd;
    bit          wr, rd;
    logic [31:0] addr, data;
    logic [3:0]  be;
    int          lat, nrd, nwr;
    logic [31:0] rdata, wdata;
  } vec_t;

  vec_t tbl [11];

  logic [31:0] sh [0:255];
  logic [31:0] last_rd;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrsp;
    tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 32'h40, 32'h0,        4'h0, 7,  1, 0, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 32'h44, 32'h12345678, 4'hF, 7,  0, 1, 32'hDEADBEEF, 32'h12345678};
    tbl[2]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h44, 32'h0,        4'h0, 7,  1, 0, 32'h12345678, 32'h0};
    tbl[3]  = '{1'b1, 8'h11, 32'hAABBCCDD, 1'b1, 1'b0, 32'h44, 32'h00001100, 4'h2, 13, 1, 1, 32'h12345678, 32'hAABB11DD};
    tbl[4]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h45, 32'h0,        4'h0, 7,  1, 0, 32'hAABB11DD, 32'h0};
    tbl[5]  = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 4'hF, 7,  0, 1, 32'hAABB11DD, 32'hCAFEF00D};
    tbl[6]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h48, 32'h0,        4'h0, 7,  1, 0, 32'hCAFEF00D, 32'h0};
    tbl[7]  = '{1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 32'h48, 32'hFFFFFFFF, 4'h0, 1,  0, 0, 32'hCAFEF00D, 32'h0};
    tbl[8]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h4B, 32'h0,        4'h0, 7,  1, 0, 32'hCAFEF00D, 32'h0};
    tbl[9]  = '{1'b1, 8'h13, 32'h11223344, 1'b1, 1'b0, 32'h4C, 32'hA5A5A5A5, 4'h9, 13, 1, 1, 32'hCAFEF00D, 32'hA52233A5};
    tbl[10] = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h4E, 32'h0,        4'h0, 7,  1, 0, 32'hA52233A5, 32'h0};

    rst = 1'b1; m_sup = 1'b0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
    core_rd_req = 1'b0; core_wr_req = 1'b0; core_addr = '0;
    core_wr_data = '0; core_byte_en = '0;

    // reset state
    @(negedge clk);
    chk("rst/ready", {31'd0, core_ready}, 32'd0);
    chk("rst/rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
    chk("rst/mem_reqs", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    chk("rst/rd_data", core_rd_data, 32'd0);
    chk("rst/mem_addr", mem_addr, 32'd0);
    chk("rst/mem_wr_data", mem_wr_data, 32'd0);
    chk("rst/err", {31'd0, core_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst/ready", {31'd0, core_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].pl) preload(tbl[i].pw, tbl[i].pd);
      txn(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].be,
          tbl[i].lat, tbl[i].nrd, tbl[i].nwr, tbl[i].rdata, tbl[i].wdata,
          1'b0, $sformatf("vec%0d", i));
    end
    chk("mem[0x11]", mem[8'h11], 32'hAABB11DD);
    chk("mem[0x12]", mem[8'h12], 32'hCAFEF00D);

    // reset while in RMW_WAIT: transaction abandoned, no response
    preload(8'h20, 32'h55667788);
    core_wr_req = 1'b1; core_addr = 32'h80; core_wr_data = 32'hFFFFFFFF; core_byte_en = 4'h2;
    @(posedge clk);
    @(negedge clk);
    core_wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort/ready", {31'd0, core_ready}, 32'd0);
    chk("abort/outs", {28'd0, core_rsp_valid, core_err, mem_rd_req, mem_wr_req}, 32'd0);
    chk("abort/rd_data", core_rd_data, 32'd0);
    chk("abort/mem_addr", mem_addr, 32'd0);
    chk("abort/mem_wr_data", mem_wr_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (core_rsp_valid || mem_wr_req) nrsp++;
    end
    chk("abort/no_rsp_or_write", nrsp, 0);
    chk("abort/mem_untouched", mem[8'h20], 32'h55667788);
    txn(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 7, 1, 0, 32'h55667788, 32'h0, 1'b0, "after_abort");
    last_rd = 32'h55667788;

    // randomized traffic vs shadow memory
    for (int w = 8'h20; w < 8'h28; w++) begin
      sh[w] = $urandom;
      preload(8'(w), sh[w]);
    end
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  w;
      logic [31:0] a, d, nw;
      logic [3:0]  be;
      int          kind, lat, nrd, nwr;
      bit          rd_too;
      w = 8'($urandom_range(8'h20, 8'h27));
      a = {22'd0, w, 2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        last_rd = sh[w];
        txn(1'b0, 1'b1, a, 32'h0, 4'($urandom), 7, 1, 0, last_rd, 32'h0, 1'b0,
            $sformatf("rnd%0d_ld", t));
      end else begin
        d  = $urandom;
        be = (kind == 1) ? 4'hF : 4'($urandom_range(0, 15));
        rd_too = ($urandom_range(0, 3) == 0);
        nw = sh[w];
        for (int b = 0; b < 4; b++)
          if (be[b]) nw[b*8 +: 8] = d[b*8 +: 8];
        if (be == 4'h0)      begin lat = 1;  nrd = 0; nwr = 0; end
        else if (be == 4'hF) begin lat = 7;  nrd = 0; nwr = 1; end
        else                 begin lat = 13; nrd = 1; nwr = 1; end
        sh[w] = nw;
        txn(1'b1, rd_too, a, d, be, lat, nrd, nwr, last_rd, nw, 1'b0,
            $sformatf("rnd%0d_st", t));
      end
    end
    @(negedge clk);
    for (int w = 8'h20; w < 8'h28; w++)
      chk($sformatf("final_mem[%0h]", w), mem[w], sh[w]);

`ifdef MEM_REQUESTER_TIMEOUT_EN
    // ack suppressed: error response after TMO wait cycles, data held
    m_sup = 1'b1;
    txn(1'b0, 1'b1, 32'h84, 32'h0, 4'h0, TMO + 2, 1, 0, last_rd, 32'h0, 1'b1, "timeout");
    m_sup = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    txn(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 7, 1, 0, sh[8'h20], 32'h0, 1'b0, "post_timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
